jtcontra_sdram_arb: RTL and testbench
=====================================

Name: jtcontra_sdram_arb

Overview:
- Four-requester SDRAM read scheduler for the Contra-family cores.
- Shares a single SDRAM read port between GFX1, GFX2, sound and main ROM clients.
- Each slot holds a one-entry cache (tag plus 16-bit word); a cache miss raises a request.
- A round-robin arbiter serialises the misses onto the SDRAM req/ack/rdy handshake. It adds the per-slot offset and blocks all traffic while a download is in progress.

Parameters:
- AW, 18, slot address width (16-bit word addresses).
- OFFSET0, 22'h0, SDRAM word offset for slot 0 (GFX1).
- OFFSET1, 22'h0, SDRAM word offset for slot 1 (GFX2).
- OFFSET2, 22'h0, SDRAM word offset for slot 2 (sound).
- OFFSET3, 22'h0, SDRAM word offset for slot 3 (main).

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- downloading  in  1  ROM download active; blocks and invalidates everything.
- slot_cs  in  4  per-slot read request, bit n = slot n.
- slot_addr  in  4*AW  per-slot word address; slot n occupies bits [n*AW +: AW].
- slot_ok  out  4  per-slot data valid for the current address.
- slot_dout  out  64  per-slot cached word; slot n occupies bits [16n +: 16].
- sdram_req  out  1  SDRAM read request.
- sdram_addr  out  22  SDRAM word address.
- sdram_ack  in  1  request accepted, 1-cycle pulse.
- data_rdy  in  1  data_read valid, 1-cycle pulse.
- data_read  in  16  SDRAM read data.

Behaviour:
- Reset values:
  - sdram_req=0, sdram_addr=0, slot_ok=0, slot_dout=0.
  - All tags=0, all valid=0.
  - FSM=IDLE, round-robin pointer=3, so slot 0 wins first.
- Hit (combinational): slot_ok[n] = slot_cs[n] & valid[n] & (slot_addr[n]==tag[n]). slot_dout[n] is always the stored word.
- Miss: pend[n] = slot_cs[n] & ~slot_ok[n] & ~downloading.
- FSM states IDLE, REQ, WAIT.
- IDLE:
  - If any pend, grant the first pending slot after the pointer (cyclic order 0..3).
  - Latch gnt and addr_l = slot_addr[gnt].
  - Drive sdram_addr = OFFSETgnt + zero-extended addr_l (22-bit add, wraps mod 2^22).
  - Set sdram_req=1 and go to REQ. Pointer := gnt.
  - Grant-to-sdram_req latency is 1 cycle.
- REQ: hold sdram_req and sdram_addr stable. On sdram_ack: sdram_req=0, go to WAIT.
- WAIT: on data_rdy:
  - tag[gnt] := addr_l, data[gnt] := data_read, valid[gnt] := 1.
  - Go to IDLE.
  - slot_ok rises the cycle after data_rdy if slot_addr still equals addr_l.
- data_rdy arriving in REQ together with sdram_ack: treat as ack followed by immediate completion; capture the data and go to IDLE.
- Address change during REQ/WAIT:
  - The transaction completes with addr_l; the slot is not re-arbitrated mid-flight.
  - A mismatch keeps slot_ok low and a new miss is issued from IDLE.
- slot_cs dropped during REQ/WAIT: the transaction completes and fills the cache anyway.
- Back-to-back: IDLE can re-grant on the cycle after completion. Minimum per-miss cost is 3 cycles plus SDRAM latency.
- Fairness: with all four slots missing continuously, grants rotate 0,1,2,3,0,... Each slot waits at most 3 other transactions.
- downloading=1 (any state):
  - Synchronous abort: sdram_req=0, FSM to IDLE, all valid cleared, slot_ok=0.
  - Stray ack/rdy arriving afterwards are ignored.
  - Requests resume the cycle after downloading falls.
- Reset mid-transaction: immediate return to the reset values; any ack/rdy outstanding in the SDRAM controller is ignored in IDLE.
- sdram_ack or data_rdy received in an unexpected state is ignored.

Decomposition:
- Shared package jtcontra_arb_pkg:
  - state enum {IDLE, REQ, WAIT}.
  - localparam NSLOT=4.
  - Round-robin next-grant function.
- One natural sub-module: jtcontra_arb_slot, instantiated 4x. It holds tag/data/valid and produces the hit/ok/pend logic, with a fill strobe from the arbiter.

Test Plan:
- Single miss: slot 2 cs=1, addr=18'h00123, OFFSET2=22'h10000.
  - sdram_req rises one cycle later with sdram_addr=22'h10123.
  - ack, then rdy with data 16'hBEEF, gives slot_ok[2]=1 and slot_dout[2]=BEEF.
  - A re-read of the same address gives no new sdram_req.
- Round-robin: all four slots miss simultaneously, SDRAM responds after 4 cycles → grant order 0,1,2,3; each slot_ok rises in that order with its own data.
- Address change in flight: slot 0 addr=5, changed to 6 during WAIT.
  - After rdy, tag=5 and slot_ok[0]=0.
  - A second request goes out for offset+6; slot_ok[0]=1 after its rdy.
- Download abort: downloading=1 during WAIT → sdram_req=0 and all slot_ok=0. A following data_rdy does not fill the cache; no requests while downloading=1.
- Ack+rdy same cycle in REQ → FSM returns to IDLE, data captured, next pending slot granted on the following cycle.
- Async reset: rst_n low mid-REQ → sdram_req=0 and slot_ok=0 immediately, without a clock edge; after release, slot 0 wins first.

Source files
------------

// File: rtl/jtcontra_sdram_arb_pkg.sv
// Shared types and helpers for the Contra SDRAM read arbiter.
// Holds the FSM state enum, the slot count and the round-robin picker.
package jtcontra_arb_pkg;

    localparam int NSLOT = 4;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } state_t;

    // First pending slot strictly after ptr in cyclic order;
    // ptr itself has the lowest priority.
    function automatic logic [1:0] rr_next(
        input logic [3:0] pend,
        input logic [1:0] ptr
    );
        logic [1:0] idx;
        rr_next = ptr;
        for (int i = 4; i >= 1; i--) begin
            idx = ptr + 2'(i);
            if (pend[idx]) rr_next = idx;
        end
    endfunction

endpackage

// File: rtl/jtcontra_sdram_arb_if.sv
// SDRAM read-port bundle between the arbiter and the SDRAM controller.
// master: drives req/addr, receives ack/rdy/data. slave: the reverse.
interface jtcontra_sdram_arb_if;

    logic        sdram_req;
    logic [21:0] sdram_addr;
    logic        sdram_ack;
    logic        data_rdy;
    logic [15:0] data_read;

    modport master (
        output sdram_req,
        output sdram_addr,
        input  sdram_ack,
        input  data_rdy,
        input  data_read
    );

    modport slave (
        input  sdram_req,
        input  sdram_addr,
        output sdram_ack,
        output data_rdy,
        output data_read
    );

endinterface

// File: rtl/jtcontra_sdram_arb_slot.sv
// One-entry read cache for a single arbiter slot: tag, word, valid.
// Ports: cs/addr from the client, fill strobe + data from the arbiter, ok/pend/dout out.
module jtcontra_arb_slot
    import jtcontra_arb_pkg::*;
#(
    parameter int AW = 18
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cs,
    input  logic [AW-1:0] addr,
    input  logic          dl,
    input  logic          fill,
    input  logic [AW-1:0] fill_addr,
    input  logic [15:0]   fill_data,
    output logic          ok,
    output logic          pend,
    output logic [15:0]   dout
);

    logic [AW-1:0] tag_q, tag_d;
    logic [15:0]   data_q, data_d;
    logic          valid_q, valid_d;

    // A download invalidates the cache, so the hit is masked at once
    // rather than one cycle later when valid drops.
    assign ok   = cs & valid_q & (addr == tag_q) & ~dl;
    assign pend = cs & ~ok & ~dl;
    assign dout = data_q;

    always_comb begin
        tag_d   = tag_q;
        data_d  = data_q;
        valid_d = valid_q;
        if (fill) begin
            tag_d   = fill_addr;
            data_d  = fill_data;
            valid_d = 1'b1;
        end
        if (dl) valid_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            tag_q   <= tag_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/jtcontra_sdram_arb.sv
// Four-slot SDRAM read scheduler: per-slot one-word caches, round-robin miss service.
// Ports: clk/rst_n, downloading, slot_cs/addr/ok/dout, bus (SDRAM req/ack/rdy master).
module jtcontra_sdram_arb
    import jtcontra_arb_pkg::*;
#(
    parameter int          AW      = 18,
    parameter logic [21:0] OFFSET0 = 22'h0,
    parameter logic [21:0] OFFSET1 = 22'h0,
    parameter logic [21:0] OFFSET2 = 22'h0,
    parameter logic [21:0] OFFSET3 = 22'h0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                downloading,
    input  logic [NSLOT-1:0]    slot_cs,
    input  logic [NSLOT*AW-1:0] slot_addr,
    output logic [NSLOT-1:0]    slot_ok,
    output logic [63:0]         slot_dout,
    jtcontra_sdram_arb_if.master bus
);

    localparam logic [21:0] OFFS [NSLOT] = '{OFFSET0, OFFSET1, OFFSET2, OFFSET3};

    state_t        state_q, state_d;
    logic [1:0]    gnt_q, gnt_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [AW-1:0] addr_l_q, addr_l_d;
    logic          req_q, req_d;
    logic [21:0]   saddr_q, saddr_d;
    logic          fill;
    logic [1:0]    nxt;
    logic [NSLOT-1:0] pend;
    logic [AW-1:0] addr_a [NSLOT];

    assign bus.sdram_req  = req_q;
    assign bus.sdram_addr = saddr_q;

    for (genvar n = 0; n < NSLOT; n++) begin : g_slot
        assign addr_a[n] = slot_addr[n*AW +: AW];
        jtcontra_arb_slot #(.AW(AW)) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .cs        (slot_cs[n]),
            .addr      (addr_a[n]),
            .dl        (downloading),
            .fill      (fill & (gnt_q == 2'(n))),
            .fill_addr (addr_l_q),
            .fill_data (bus.data_read),
            .ok        (slot_ok[n]),
            .pend      (pend[n]),
            .dout      (slot_dout[16*n +: 16])
        );
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        ptr_d    = ptr_q;
        addr_l_d = addr_l_q;
        req_d    = req_q;
        saddr_d  = saddr_q;
        fill     = 1'b0;
        nxt      = rr_next(pend, ptr_q);
        unique case (state_q)
            IDLE: begin
                if (|pend) begin
                    gnt_d    = nxt;
                    ptr_d    = nxt;
                    addr_l_d = addr_a[nxt];
                    saddr_d  = OFFS[nxt] + 22'(addr_a[nxt]);
                    req_d    = 1'b1;
                    state_d  = REQ;
                end
            end
            REQ: begin
                if (bus.sdram_ack) begin
                    req_d = 1'b0;
                    // ack and rdy together: the read already completed
                    if (bus.data_rdy) begin
                        fill    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (bus.data_rdy) begin
                    fill    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (downloading) begin
            req_d   = 1'b0;
            state_d = IDLE;
            fill    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            gnt_q    <= 2'd0;
            ptr_q    <= 2'd3;
            addr_l_q <= '0;
            req_q    <= 1'b0;
            saddr_q  <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            ptr_q    <= ptr_d;
            addr_l_q <= addr_l_d;
            req_q    <= req_d;
            saddr_q  <= saddr_d;
        end
    end

endmodule

// File: tb/tb_jtcontra_sdram_arb.sv
// Directed bench for jtcontra_sdram_arb: miss/hit, round-robin, in-flight
// address change, download abort, ack+rdy collapse and async reset.
module tb_jtcontra_sdram_arb;

    localparam int AW = 18;

    logic          clk;
    logic          rst_n;
    logic          downloading;
    logic [3:0]    slot_cs;
    logic [4*AW-1:0] slot_addr;
    logic [3:0]    slot_ok;
    logic [63:0]   slot_dout;

    int checks;
    int failures;

    jtcontra_sdram_arb_if bus ();

    jtcontra_sdram_arb #(
        .AW      (AW),
        .OFFSET0 (22'h200000),
        .OFFSET1 (22'h300000),
        .OFFSET2 (22'h010000),
        .OFFSET3 (22'h3FFFF0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .downloading (downloading),
        .slot_cs     (slot_cs),
        .slot_addr   (slot_addr),
        .slot_ok     (slot_ok),
        .slot_dout   (slot_dout),
        .bus         (bus.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tk();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_addr(input int n, input logic [AW-1:0] a);
        slot_addr[n*AW +: AW] = a;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        #1;
    endtask

    logic [21:0] rr_exp [4];
    logic [15:0] dat;

    initial begin
        checks        = 0;
        failures      = 0;
        rst_n         = 1'b0;
        downloading   = 1'b0;
        slot_cs       = 4'h0;
        slot_addr     = '0;
        bus.sdram_ack = 1'b0;
        bus.data_rdy  = 1'b0;
        bus.data_read = 16'h0;
        #1;
        chk("rst_req", bus.sdram_req, 1'b0);
        chk("rst_addr", bus.sdram_addr, 22'h0);
        chk("rst_ok", slot_ok, 4'h0);
        chk("rst_dout", slot_dout, 64'h0);
        tk();
        rst_n = 1'b1;
        tk();

        // single miss on slot 2
        slot_cs = 4'b0100;
        set_addr(2, 18'h00123);
        #1;
        chk("t1_miss_ok", slot_ok, 4'h0);
        tk();
        chk("t1_req", bus.sdram_req, 1'b1);
        chk("t1_addr", bus.sdram_addr, 22'h010123);
        tk();
        chk("t1_req_hold", bus.sdram_req, 1'b1);
        chk("t1_addr_hold", bus.sdram_addr, 22'h010123);
        bus.sdram_ack = 1'b1;
        tk();
        bus.sdram_ack = 1'b0;
        chk("t1_req_drop", bus.sdram_req, 1'b0);
        bus.data_rdy  = 1'b1;
        bus.data_read = 16'hBEEF;
        tk();
        bus.data_rdy = 1'b0;
        chk("t1_ok", slot_ok, 4'b0100);
        chk("t1_dout", slot_dout, 64'h0000_BEEF_0000_0000);
        tk();
        tk();
        chk("t1_reread_noreq", bus.sdram_req, 1'b0);
        chk("t1_reread_ok", slot_ok, 4'b0100);

        // round-robin with all four slots missing
        do_reset();
        slot_cs = 4'hF;
        set_addr(0, 18'h00010);
        set_addr(1, 18'h00011);
        set_addr(2, 18'h00012);
        set_addr(3, 18'h00020);
        rr_exp[0] = 22'h200010;
        rr_exp[1] = 22'h300011;
        rr_exp[2] = 22'h010012;
        rr_exp[3] = 22'h000010;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 8 && !bus.sdram_req; i++) tk();
            chk("rr_req", bus.sdram_req, 1'b1);
            chk("rr_addr", bus.sdram_addr, rr_exp[k]);
            bus.sdram_ack = 1'b1;
            tk();
            bus.sdram_ack = 1'b0;
            tk();
            tk();
            tk();
            dat           = 16'hA000 + 16'(k);
            bus.data_rdy  = 1'b1;
            bus.data_read = dat;
            tk();
            bus.data_rdy = 1'b0;
            chk("rr_ok", slot_ok, 64'((1 << (k + 1)) - 1));
        end
        chk("rr_dout", slot_dout, 64'hA003_A002_A001_A000);

        // address change while slot 0 is in flight
        slot_cs = 4'b0001;
        set_addr(0, 18'h00005);
        tk();
        chk("t3_addr1", bus.sdram_addr, 22'h200005);
        bus.sdram_ack = 1'b1;
        tk();
        bus.sdram_ack = 1'b0;
        set_addr(0, 18'h00006);
        bus.data_rdy  = 1'b1;
        bus.data_read = 16'h1111;
        tk();
        bus.data_rdy = 1'b0;
        chk("t3_mismatch_ok", slot_ok, 4'b0000);
        chk("t3_dout", slot_dout[15:0], 16'h1111);
        set_addr(0, 18'h00005);
        #1;
        chk("t3_tag5_ok", slot_ok, 4'b0001);
        set_addr(0, 18'h00006);
        #1;
        tk();
        chk("t3_req2", bus.sdram_req, 1'b1);
        chk("t3_addr2", bus.sdram_addr, 22'h200006);
        bus.sdram_ack = 1'b1;
        tk();
        bus.sdram_ack = 1'b0;
        bus.data_rdy  = 1'b1;
        bus.data_read = 16'h2222;
        tk();
        bus.data_rdy = 1'b0;
        chk("t3_ok2", slot_ok, 4'b0001);
        chk("t3_dout2", slot_dout[15:0], 16'h2222);

        // download abort during WAIT
        slot_cs = 4'b0011;
        set_addr(1, 18'h00040);
        #1;
        chk("t4_pre_ok", slot_ok, 4'b0001);
        tk();
        chk("t4_addr", bus.sdram_addr, 22'h300040);
        bus.sdram_ack = 1'b1;
        tk();
        bus.sdram_ack = 1'b0;
        downloading = 1'b1;
        tk();
        chk("t4_dl_req", bus.sdram_req, 1'b0);
        chk("t4_dl_ok", slot_ok, 4'b0000);
        bus.data_rdy  = 1'b1;
        bus.data_read = 16'h5555;
        tk();
        bus.data_rdy = 1'b0;
        tk();
        chk("t4_dl_noreq", bus.sdram_req, 1'b0);
        downloading = 1'b0;
        #1;
        chk("t4_post_ok", slot_ok, 4'b0000);
        chk("t4_nofill", slot_dout[31:16], 16'hA001);
        tk();
        chk("t4_resume_req", bus.sdram_req, 1'b1);
        chk("t4_resume_addr", bus.sdram_addr, 22'h200006);

        // ack and rdy in the same cycle while in REQ
        bus.sdram_ack = 1'b1;
        bus.data_rdy  = 1'b1;
        bus.data_read = 16'h7777;
        tk();
        bus.sdram_ack = 1'b0;
        bus.data_rdy  = 1'b0;
        chk("t5_ok", slot_ok, 4'b0001);
        chk("t5_dout", slot_dout[15:0], 16'h7777);
        chk("t5_req_low", bus.sdram_req, 1'b0);
        tk();
        chk("t5_next_req", bus.sdram_req, 1'b1);
        chk("t5_next_addr", bus.sdram_addr, 22'h300040);
        bus.sdram_ack = 1'b1;
        tk();
        bus.sdram_ack = 1'b0;
        bus.data_rdy  = 1'b1;
        bus.data_read = 16'h8888;
        tk();
        bus.data_rdy = 1'b0;
        chk("t5_ok2", slot_ok, 4'b0011);
        chk("t5_dout2", slot_dout[31:16], 16'h8888);

        // async reset mid-REQ, slot 3 with offset wrap
        slot_cs = 4'b1011;
        set_addr(3, 18'h00055);
        tk();
        chk("t6_req", bus.sdram_req, 1'b1);
        chk("t6_wrap_addr", bus.sdram_addr, 22'h000045);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_req", bus.sdram_req, 1'b0);
        chk("t6_async_addr", bus.sdram_addr, 22'h0);
        chk("t6_async_ok", slot_ok, 4'h0);
        chk("t6_async_dout", slot_dout, 64'h0);
        #2;
        rst_n = 1'b1;
        bus.sdram_ack = 1'b1;
        tk();
        bus.sdram_ack = 1'b0;
        chk("t6_first_req", bus.sdram_req, 1'b1);
        chk("t6_first_addr", bus.sdram_addr, 22'h200006);
        bus.sdram_ack = 1'b1;
        tk();
        bus.sdram_ack = 1'b0;
        bus.data_rdy  = 1'b1;
        bus.data_read = 16'h9999;
        tk();
        bus.data_rdy = 1'b0;
        chk("t6_ok", slot_ok, 4'b0001);
        tk();
        chk("t6_second_addr", bus.sdram_addr, 22'h300040);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
